pdm_cic_decimator: RTL and testbench

- Receive-side counterpart of the audio path's PDM modulator: drives the clock for an external PDM microphone, captures its 1-bit stream and decimates it to 16-bit signed PCM.
- Uses a 3rd-order CIC filter; one PCM word is produced every DECIM PDM bits.
- Sits at the front of the equalizer input chain and feeds the filter bank through a valid strobe.

---
 rtl/pdm_cic_decimator.sv | 193 +++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
// -----------------
// Drives the clock for an external PDM microphone, captures its 1-bit stream
// and decimates it by 64 with a 3rd-order CIC filter to 16-bit signed PCM.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous, active-low reset (clears everything, including pcm)
//   en        run enable; low holds mic_clk at 0 and clears all filter state
//   pdm_data  asynchronous 1-bit data from the microphone
//   mic_clk   PDM clock to the microphone (CLK_DIV clks per half period)
//   pcm       signed PCM sample, held between pcm_vld pulses
//   pcm_vld   one-clk pulse marking a new pcm value
//
// Build option:
//   PDM_RISE_SAMPLE_EN  when defined, the bit is taken in the last cycle of the
//                       mic_clk low phase instead of the high phase (selects the
//                       other channel of an L/R-shared microphone line).
module pdm_cic_decimator #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               pdm_data,
    output logic               mic_clk,
    output logic signed [15:0] pcm,
    output logic               pcm_vld
);

    localparam int DATA_W = 16;
    localparam int ACC_W  = 20;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = $clog2(DECIM);

    localparam logic signed [ACC_W-1:0] ONE = 20'sd1;

    generate
        if (DECIM != 64) begin : g_bad_decim
            $error("pdm_cic_decimator: DECIM must be 64 (output scaling assumes gain 2^18)");
        end
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
            $error("pdm_cic_decimator: CLK_DIV must lie in 2..255");
        end
    endgenerate

    // Gain of the filter is 64^3 = 2^18; dropping 3 bits leaves 2^15 full scale.
    // Only the all-ones input reaches +32768, which is clamped.
    function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] d);
        logic signed [ACC_W-4:0] q;
        q = d[ACC_W-1:3];
        if (q > 17'sd32767) begin
            return 16'sh7fff;
        end
        return q[DATA_W-1:0];
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             strobe;

    assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The strobe is the last cycle of the chosen mic_clk phase, so the data
    // has had a whole half period to settle through the synchronizer.
`ifdef PDM_RISE_SAMPLE_EN
    assign strobe = en && div_wrap && !mic_clk;
`else
    assign strobe = en && div_wrap && mic_clk;
`endif

    // ---- input synchronizer ----
    logic pdm_p0;
    logic pdm_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_p0 <= 1'b0;
            pdm_p1 <= 1'b0;
        end else begin
            pdm_p0 <= pdm_data;
            pdm_p1 <= pdm_p0;
        end
    end

    // ---- integrator stage (runs at the PDM bit rate) ----
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] integ1, integ2, integ3;
    logic signed [ACC_W-1:0] integ1_nx, integ2_nx, integ3_nx;
    logic        [CNT_W-1:0] bit_cnt;
    logic signed [ACC_W-1:0] dec_p1;
    logic                    vld_p1;

    assign x_ext     = pdm_p1 ? ONE : -ONE;
    assign integ1_nx = integ1 + x_ext;
    assign integ2_nx = integ2 + integ1_nx;
    assign integ3_nx = integ3 + integ2_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            bit_cnt <= '0;
            dec_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (!en) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            bit_cnt <= '0;
            dec_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (strobe) begin
                integ1  <= integ1_nx;
                integ2  <= integ2_nx;
                integ3  <= integ3_nx;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(DECIM - 1)) begin
                    dec_p1 <= integ3_nx;
                    vld_p1 <= 1'b1;
                end
            end
        end
    end

    // ---- comb stage (runs at the decimated rate) ----
    // Differences are taken modulo 2^20; the wrap in the integrators cancels.
    logic signed [ACC_W-1:0] dly1, dly2, dly3;
    logic signed [ACC_W-1:0] comb1, comb2, comb3;
    logic        [1:0]       fill;

    assign comb1 = dec_p1 - dly1;
    assign comb2 = comb1 - dly2;
    assign comb3 = comb2 - dly3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly1 <= '0;
            dly2 <= '0;
            dly3 <= '0;
        end else if (!en) begin
            dly1 <= '0;
            dly2 <= '0;
            dly3 <= '0;
        end else if (vld_p1) begin
            dly1 <= dec_p1;
            dly2 <= comb1;
            dly3 <= comb2;
        end
    end

    // ---- output stage ----
    // The first three results only prime the comb delays and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm     <= '0;
            pcm_vld <= 1'b0;
            fill    <= '0;
        end else begin
            pcm_vld <= 1'b0;
            if (!en) begin
                fill <= '0;
            end else if (vld_p1) begin
                if (fill == 2'd3) begin
                    pcm     <= scale_sat(comb3);
                    pcm_vld <= 1'b1;
                end else begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
`timescale 1ns/1ps
module tb_pdm_cic_decimator;

    localparam int CLK_DIV  = 16;
    localparam int DECIM    = 64;
    localparam int WIN_CLKS = 2 * CLK_DIV * DECIM;
    localparam int HLEN     = 3 * (DECIM - 1) + 1;
`ifdef PDM_RISE_SAMPLE_EN
    // new bit one clk after mic_clk falls (and at start-up)
    localparam int DRIVE_PH = 1;
`else
    // new bit right after mic_clk rises
    localparam int DRIVE_PH = CLK_DIV;
`endif

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               en       = 1'b0;
    logic               pdm_data = 1'b0;
    logic               mic_clk;
    logic signed [15:0] pcm;
    logic               pcm_vld;

    pdm_cic_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pdm_data (pdm_data),
        .mic_clk  (mic_clk),
        .pcm      (pcm),
        .pcm_vld  (pcm_vld)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int h[HLEN];          // impulse response of three cascaded 64-tap boxcars
    int hist[$];          // +1/-1 bits driven since the current run started
    int expq[$];          // pcm values still owed by the DUT
    int t        = 0;     // clks since en rose (0 while idle/reset)
    int mic_exp  = 0;
    int mode     = 0;
    int pcm_hold = 0;
    int cyc      = 0;
    int last_vld = 0;
    bit have_last = 1'b0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int model_out();
        int n = hist.size();
        int y = 0;
        int s;
        for (int k = 0; k < HLEN; k++) begin
            if (n - 1 - k >= 0) y += h[k] * hist[n - 1 - k];
        end
        s = y >>> 3;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    task automatic clear_model();
        hist.delete();
        expq.delete();
        have_last = 1'b0;
    endtask

    task automatic drive_bit();
        int b;
        int i = hist.size();
        case (mode)
            1:       b = 1;
            2:       b = 0;
            3:       b = (i % 2 == 0) ? 1 : 0;
            4:       b = (i % 4 != 3) ? 1 : 0;
            5:       b = (i % 4 == 0) ? 1 : 0;
            default: b = int'($urandom_range(0, 1));
        endcase
        pdm_data = (b != 0);
        hist.push_back((b != 0) ? 1 : -1);
        if (hist.size() % DECIM == 0 && hist.size() / DECIM > 3)
            expq.push_back(model_out());
    endtask

    // One clk of the model; returns 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n && en) begin
            t++;
        end else begin
            t = 0;
            clear_model();
        end
        mic_exp = (t / CLK_DIV) % 2;
        if (t > 0 && (t % (2 * CLK_DIV)) == DRIVE_PH) drive_bit();
    endtask

    task automatic settle(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_bits(input int m, input int nbits);
        int target;
        int budget;
        mode   = m;
        target = hist.size() + nbits;
        budget = nbits * 2 * CLK_DIV + 4 * CLK_DIV;
        while (hist.size() < target && budget > 0) begin
            cycle();
            budget--;
        end
        chk("bits_driven", hist.size(), target);
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_mic_clk", int'(mic_clk), 0);
            chk("rst_pcm", int'(pcm), 0);
            chk("rst_pcm_vld", int'(pcm_vld), 0);
            pcm_hold = 0;
        end else begin
            chk("mic_clk", int'(mic_clk), mic_exp);
            if (pcm_vld) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pcm_vld", 1, 0);
                end else begin
                    pcm_hold = expq.pop_front();
                    chk("pcm_value", int'(pcm), pcm_hold);
                end
                if (have_last) chk("vld_spacing", cyc - last_vld, WIN_CLKS);
                last_vld  = cyc;
                have_last = 1'b1;
            end else begin
                chk("pcm_hold", int'(pcm), pcm_hold);
            end
        end
    end

    initial begin
        int h2[2 * DECIM - 1];
        int hsum;

        // impulse response: boxcar * boxcar * boxcar
        foreach (h2[i]) h2[i] = 0;
        foreach (h[i]) h[i] = 0;
        for (int i = 0; i < DECIM; i++)
            for (int j = 0; j < DECIM; j++) h2[i + j] += 1;
        for (int i = 0; i < 2 * DECIM - 1; i++)
            for (int j = 0; j < DECIM; j++) h[i + j] += h2[i];
        hsum = 0;
        foreach (h[i]) hsum += h[i];
        chk("model_gain", hsum, 262144);
        chk("model_h0", h[0], 1);
        chk("model_h2", h[2], 6);
        chk("model_hlast", h[HLEN - 1], 1);

        rst_n = 1'b0;
        en    = 1'b0;
        settle(3);
        rst_n = 1'b1;
        settle(2);
        en = 1'b1;

        run_bits(1, 6 * DECIM); settle(CLK_DIV + 4);
        chk("ones_pcm", int'(pcm), 32767);
        run_bits(2, 4 * DECIM); settle(CLK_DIV + 4);
        chk("zeros_pcm", int'(pcm), -32768);
        run_bits(3, 4 * DECIM); settle(CLK_DIV + 4);
        chk("alt10_pcm", int'(pcm), 0);
        run_bits(5, 4 * DECIM); settle(CLK_DIV + 4);
        chk("p1000_pcm", int'(pcm), -16384);
        run_bits(0, 2 * DECIM);
        run_bits(4, 4 * DECIM); settle(CLK_DIV + 4);
        chk("p1110_pcm", int'(pcm), 16384);
        chk("owed_before_en_drop", expq.size(), 0);

        // en dropped mid-window
        run_bits(4, 20);
        en = 1'b0;
        cycle();
        chk("mic_clk_after_en_drop", int'(mic_clk), 0);
        settle(3000);
        chk("pcm_kept_en_low", int'(pcm), 16384);

        // restart: three windows discarded, then random data resumes output
        en = 1'b1;
        run_bits(0, 5 * DECIM); settle(CLK_DIV + 4);
        chk("owed_before_rst", expq.size(), 0);

        // asynchronous reset pulse mid-window
        run_bits(0, 20);
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("rst_now_pcm", int'(pcm), 0);
        chk("rst_now_vld", int'(pcm_vld), 0);
        chk("rst_now_mic", int'(mic_clk), 0);
        settle(3);
        rst_n = 1'b1;
        run_bits(4, 5 * DECIM); settle(CLK_DIV + 4);
        chk("p1110_after_rst", int'(pcm), 16384);
        chk("owed_at_end", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
